// File: rtl/parser_input_arbiter.sv
// parser_input_arbiter
// Packet-granular round-robin arbiter that shares the 32-bit parser receive
// port among NUM_SRC upstream packet sources. A grant is held from the header
// word to the last word, so packets never interleave. A stall watchdog injects
// a terminating last word when the granted source goes quiet mid-packet, so the
// parser always returns to its idle state.
//
// Build option: define PARSER_ARB_PRIO_EN to make source 0 strict-priority.
// Round-robin then covers sources 1..NUM_SRC-1 only. Without the macro, all
// sources share one round-robin ring.
module parser_input_arbiter #(
   parameter int NUM_SRC = 4,   // number of upstream sources, 2..16
   parameter int TIMEOUT = 64,  // mid-packet stall cycles before abort, 0 = off
   parameter int CNT_W   = 8    // watchdog counter width, TIMEOUT < 2**CNT_W
) (
   input  logic                       clk,
   input  logic                       reset_b,
   input  logic [NUM_SRC*32-1:0]      src_data,
   input  logic [NUM_SRC-1:0]         src_val,
   input  logic [NUM_SRC-1:0]         src_last,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic [31:0]                dataIn,
   output logic                       dataIn_val,
   input  logic                       dataIn_ready,
   output logic                       dataIN_last,
   output logic [$clog2(NUM_SRC)-1:0] grant_id,
   output logic                       busy,
   output logic                       abort_pulse
);

   localparam int ID_W = $clog2(NUM_SRC);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

`ifdef PARSER_ARB_PRIO_EN
   // Source 0 is served outside the ring; it never enters the rotation.
   localparam logic [NUM_SRC-1:0] RR_ELIGIBLE = ~(NUM_SRC'(1));
`else
   localparam logic [NUM_SRC-1:0] RR_ELIGIBLE = '1;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      ABORT = 2'd2
   } arbState_t;

   arbState_t         stateReg,    stateNext;
   logic [ID_W-1:0]   rrPtrReg,    rrPtrNext;
   logic [ID_W-1:0]   grantIdReg,  grantIdNext;
   logic [CNT_W-1:0]  stallCntReg, stallCntNext;

   // Unpacked view of the flat source bus.
   logic [31:0]       srcWord [NUM_SRC];
   // One-hot decode of the current grant.
   logic [NUM_SRC-1:0] grantOneHot;

   // Granted-source views used by the pass-through path.
   logic [31:0]       gWord;
   logic              gVal;
   logic              gLast;

   // Arbitration results.
   logic              rrFound;
   logic [ID_W-1:0]   rrIdx;
   logic              prioHit;
   logic              grantValid;
   logic [ID_W-1:0]   grantPick;
   logic              rrUpdate;
   int                cand;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign srcWord[gi]     = src_data[32*gi +: 32];
         assign grantOneHot[gi] = (grantIdReg == ID_W'(gi));
      end
   endgenerate

   assign gWord = srcWord[grantIdReg];
   assign gVal  = src_val[grantIdReg];
   assign gLast = src_last[grantIdReg];

`ifdef PARSER_ARB_PRIO_EN
   assign prioHit  = src_val[0];
   // Grants to the priority source leave the ring position untouched.
   assign rrUpdate = (grantIdReg != '0);
`else
   assign prioHit  = 1'b0;
   assign rrUpdate = 1'b1;
`endif

   // Round-robin search: first eligible requester after rrPtrReg, wrapping.
   always_comb begin
      rrFound = 1'b0;
      rrIdx   = '0;
      cand    = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = int'(rrPtrReg) + k;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         if (!rrFound && src_val[ID_W'(cand)] && RR_ELIGIBLE[ID_W'(cand)]) begin
            rrFound = 1'b1;
            rrIdx   = ID_W'(cand);
         end
      end
   end

   // Final pick: the priority source (when enabled) beats the ring.
   always_comb begin
      grantValid = prioHit | rrFound;
      grantPick  = prioHit ? '0 : rrIdx;
   end

   // Next-state, counters and parser-side outputs; idle values assigned first.
   always_comb begin
      stateNext    = stateReg;
      rrPtrNext    = rrPtrReg;
      grantIdNext  = grantIdReg;
      stallCntNext = stallCntReg;
      dataIn       = '0;
      dataIn_val   = 1'b0;
      dataIN_last  = 1'b0;
      src_ready    = '0;
      busy         = 1'b0;
      abort_pulse  = 1'b0;

      case (stateReg)
         IDLE: begin
            if (grantValid) begin
               grantIdNext  = grantPick;
               stallCntNext = '0;
               stateNext    = PASS;
            end
         end

         PASS: begin
            busy        = 1'b1;
            dataIn      = gWord;
            dataIn_val  = gVal;
            dataIN_last = gLast;
            src_ready   = grantOneHot & {NUM_SRC{dataIn_ready}};
            if (gVal && dataIn_ready) begin
               // Word accepted: the source is alive, restart the watchdog.
               stallCntNext = '0;
               if (gLast) begin
                  stateNext = IDLE;
                  if (rrUpdate) begin
                     rrPtrNext = grantIdReg;
                  end
               end
            end else if (!gVal) begin
               // Source starvation mid-packet; parser backpressure never counts.
               if (stallCntReg != CNT_MAX) begin
                  stallCntNext = stallCntReg + 1'b1;
               end
               if ((TIMEOUT != 0) && (stallCntNext == TIMEOUT_CNT)) begin
                  stateNext = ABORT;
               end
            end
         end

         ABORT: begin
            // Synthetic zero last word closes the parser's frame.
            busy        = 1'b1;
            dataIn_val  = 1'b1;
            dataIN_last = 1'b1;
            if (dataIn_ready) begin
               abort_pulse = 1'b1;
               stateNext   = IDLE;
               if (rrUpdate) begin
                  rrPtrNext = grantIdReg;
               end
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, ring pointer, grant and watchdog registers.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stateReg    <= IDLE;
         rrPtrReg    <= ID_W'(NUM_SRC - 1);
         grantIdReg  <= '0;
         stallCntReg <= '0;
      end else begin
         stateReg    <= stateNext;
         rrPtrReg    <= rrPtrNext;
         grantIdReg  <= grantIdNext;
         stallCntReg <= stallCntNext;
      end
   end

   assign grant_id = grantIdReg;

endmodule

// File: doc/parser_input_arbiter.md
Name: parser_input_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single 32-bit parser receive interface (dataIn/dataIn_val/dataIn_ready/dataIN_last) among NUM_SRC upstream packet sources. A grant holds for a whole packet, from header word to last word, so parser framing is never interleaved. A stall watchdog injects a terminating last word if the granted source stops mid-packet, so the parser always returns to IDLE. Sits directly in front of the parser input port.

Parameters:
NUM_SRC, 4, number of upstream sources (2..16)
TIMEOUT, 64, consecutive mid-packet stall cycles before abort; 0 disables the watchdog
CNT_W, 8, watchdog counter width; TIMEOUT must be < 2**CNT_W

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous active-low reset
src_data  in  NUM_SRC*32  source words; source i occupies bits [32i+31:32i]
src_val  in  NUM_SRC  per-source word valid
src_last  in  NUM_SRC  per-source last word of packet
src_ready  out  NUM_SRC  per-source ready; only the granted bit can be 1
dataIn  out  32  word to parser
dataIn_val  out  1  valid to parser
dataIn_ready  in  1  parser ready
dataIN_last  out  1  last to parser
grant_id  out  $clog2(NUM_SRC)  currently or last granted source
busy  out  1  1 in PASS or ABORT
abort_pulse  out  1  one-cycle pulse when an injected abort word is accepted

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, rr_ptr=NUM_SRC-1, grant_id=0, stall_cnt=0, abort_pulse=0. All outputs 0.
- Transfer = dataIn_val & dataIn_ready.
- IDLE:
  - Outputs idle: dataIn=0, dataIn_val=0, dataIN_last=0, src_ready=0.
  - If any src_val is set, register grant_id = first requesting index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC; go to PASS.
  - Grant latency is 1 cycle. The first word can transfer in the cycle after the request is sampled.
- PASS (combinational pass-through from the granted source g):
  - dataIn=src_data[g], dataIn_val=src_val[g], dataIN_last=src_last[g], src_ready[g]=dataIn_ready. All other src_ready bits are 0.
  - On a transfer with src_last[g]=1: rr_ptr<=g, go to IDLE. The next packet needs one IDLE cycle (1-cycle bubble between packets).
  - A one-word packet (last on the header word) is passed through unchanged; the parser handles it as bad length.
  - Watchdog: stall_cnt increments on each PASS cycle with src_val[g]=0. It clears on any transfer and on entry to PASS.
  - When TIMEOUT!=0 and stall_cnt reaches TIMEOUT: go to ABORT.
  - Cycles with dataIn_ready=0 and src_val[g]=1 are backpressure, not stalls, and do not count.
- ABORT:
  - dataIn=32'h0, dataIn_val=1, dataIN_last=1, src_ready=0.
  - Hold until dataIn_ready. On that transfer: abort_pulse=1 for that cycle, rr_ptr<=g, go to IDLE.
  - The rest of the aborted packet is not dropped here. The source sees it as a fresh packet on its next grant; upstream must flush.
- grant_id holds its value in IDLE until the next grant.
- busy=1 in PASS/ABORT, 0 in IDLE.
- Simultaneous requests: only the round-robin order matters; arrival order is ignored.
- src_val changing in a non-granted source has no effect until IDLE.
- Reset mid-packet: immediate return to IDLE; outputs deassert asynchronously. The parser is in the same reset domain.

Optional Feature:
- Macro PARSER_ARB_PRIO_EN.
- Defined: source 0 is strict-priority. In IDLE, src_val[0] wins unconditionally. Round-robin applies only among sources 1..NUM_SRC-1, and rr_ptr is updated only by grants to those sources. A packet in progress is never preempted.
- Undefined: pure round-robin over all sources as above.

Test Plan:
- Single source 0 sends 4-word packet (hdr 32'h1000_0005, seq, 2 data, last on word 4), dataIn_ready=1 -> grant_id=0 one cycle after src_val; 4 words forwarded unchanged; IDLE for 1 cycle after last.
- Sources 0..3 all request continuously with 3-word packets -> grant order 0,1,2,3,0; no interleaving; src_ready only on the granted bit.
- Parser backpressure: dataIn_ready=0 for 10 cycles mid-packet, TIMEOUT=4 -> no abort; the word is held stable; stall_cnt stays 0.
- Source 2 drops src_val after the header for 64 cycles (TIMEOUT=64) -> ABORT entered at cycle 64; dataIn=0, last=1 until ready; abort_pulse for 1 cycle; next grant goes to source 3 if it is requesting.
- Reset asserted mid-packet during PASS -> dataIn_val, src_ready and busy go to 0 immediately; after release, the first grant goes to source 0.
- With PARSER_ARB_PRIO_EN defined, sources 0 and 1 requesting continuously -> source 0 is granted on every arbitration; source 1 is granted only when src_val[0]=0 in IDLE.
